// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl: multicycle ARM main control FSM with memory-ready handshake
module arm_multicycle_ctrl #(
   parameter logic MEM_WAIT = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       shR,
   input  logic       MemReady,
   output logic       IRWrite,
   output logic       NextPC,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       ALUOp,
   output logic       EscaSrc,
   output logic       LSrc,
   output logic       Illegal
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECRS, EXECI,
      ALUWB, BRANCH, BLINK, ERROR
   } state_t;
   state_t state, next;
   logic ready, irw, regw, memw, br;
   logic unused_funct;
   assign unused_funct = ^Funct[3:1];
   assign ready = MemReady | ~MEM_WAIT;
   // strobes are forced low while reset is held so no write can slip through
   assign IRWrite = irw & reset;
   assign NextPC  = irw & reset;
   assign RegW    = regw & reset;
   assign MemW    = memw & reset;
   assign Branch  = br & reset;
   assign Illegal = state == ERROR;
   // state register; async active-low reset aborts any instruction
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= FETCH;
      else        state <= next;
   // next-state decode and per-state datapath controls
   always_comb begin
      next      = state;
      irw       = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      regw      = 1'b0;
      memw      = 1'b0;
      br        = 1'b0;
      ALUOp     = 1'b0;
      EscaSrc   = 1'b0;
      LSrc      = 1'b0;
      case (state)
         FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            irw       = ready;
            next      = ready ? DECODE : FETCH;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            next      = Op == 2'b01 ? MEMADR :
                        Op == 2'b00 ? (Funct[5] ? EXECI : shR ? EXECRS : EXECR) :
                        Op == 2'b10 ? (Funct[4] ? BLINK : BRANCH) : ERROR;
         end
         MEMADR: begin
            ALUSrcB = Funct[5] ? 2'b00 : 2'b01;
            next    = Funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            AdrSrc = 1'b1;
            next   = ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            regw      = 1'b1;
            next      = FETCH;
         end
         MEMWR: begin
            AdrSrc = 1'b1;
            memw   = 1'b1;
            next   = ready ? FETCH : MEMWR;
         end
         EXECR, EXECRS: begin
            ALUOp   = 1'b1;
            EscaSrc = state == EXECRS;
            next    = ALUWB;
         end
         EXECI: begin
            ALUSrcB = 2'b01;
            ALUOp   = 1'b1;
            next    = ALUWB;
         end
         ALUWB: begin
            regw = 1'b1;
            next = FETCH;
         end
         BLINK: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            regw      = 1'b1;
            LSrc      = 1'b1;
            next      = BRANCH;
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            br        = 1'b1;
            next      = FETCH;
         end
         ERROR:   next = ERROR;
         default: next = FETCH;
      endcase
   end
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb_arm_multicycle_ctrl: per-cycle control-vector checks against an instruction-level model
module tb_arm_multicycle_ctrl;
   logic clk = 1'b0, reset = 1'b0;
   logic [1:0] Op = 2'b00;
   logic [5:0] Funct = 6'd0;
   logic shR = 1'b0, MemReady = 1'b1;
   logic IRWrite, NextPC, AdrSrc, ALUSrcA, RegW, MemW, Branch, ALUOp, EscaSrc, LSrc, Illegal;
   logic [1:0] ALUSrcB, ResultSrc;
   int errors = 0, checks = 0;
   logic [14:0] exp_q[$];
   bit rdy_q[$];

   arm_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .shR(shR), .MemReady(MemReady),
      .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .RegW(RegW), .MemW(MemW),
      .Branch(Branch), .ALUOp(ALUOp), .EscaSrc(EscaSrc), .LSrc(LSrc), .Illegal(Illegal)
   );

   always #5 clk = ~clk;

   wire [14:0] obs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                      RegW, MemW, Branch, ALUOp, EscaSrc, LSrc, Illegal};

   function automatic logic [14:0] mk(input logic irw, npc, adr, sa, input logic [1:0] sb, rs,
                                      input logic rw, mw, br, ao, es, ls, il);
      return {irw, npc, adr, sa, sb, rs, rw, mw, br, ao, es, ls, il};
   endfunction

   // PC+4 / PC+8 path used by fetch and decode (and seen while reset is held)
   localparam logic [14:0] PCV = 15'b0001_10_10_0000000;

   task automatic chk(input string tag, input logic [14:0] e);
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
   endtask

   task automatic push(input logic [14:0] v, input bit r);
      exp_q.push_back(v);
      rdy_q.push_back(r);
   endtask

   // expected cycle-by-cycle controls for one instruction, from its class and memory waits
   task automatic build(input logic [1:0] op, input logic [5:0] f, input logic s,
                        input int wf, input int wm);
      Op = op; Funct = f; shR = s;
      repeat (wf) push(PCV, 1'b0);
      push(PCV | mk(1,1,0,0,0,0,0,0,0,0,0,0,0), 1'b1);
      push(PCV, 1'($urandom));
      if (op == 2'b01) begin
         push(mk(0,0,0,0, f[5] ? 2'b00 : 2'b01, 0,0,0,0,0,0,0,0), 1'($urandom));
         if (f[0]) begin
            repeat (wm) push(mk(0,0,1,0,0,0,0,0,0,0,0,0,0), 1'b0);
            push(mk(0,0,1,0,0,0,0,0,0,0,0,0,0), 1'b1);
            push(mk(0,0,0,0,0,2'b01,1,0,0,0,0,0,0), 1'($urandom));
         end else begin
            repeat (wm) push(mk(0,0,1,0,0,0,0,1,0,0,0,0,0), 1'b0);
            push(mk(0,0,1,0,0,0,0,1,0,0,0,0,0), 1'b1);
         end
      end else if (op == 2'b00) begin
         push(mk(0,0,0,0, f[5] ? 2'b01 : 2'b00, 0,0,0,0,1, ~f[5] & s, 0,0), 1'($urandom));
         push(mk(0,0,0,0,0,0,1,0,0,0,0,0,0), 1'($urandom));
      end else if (op == 2'b10) begin
         if (f[4]) push(mk(0,0,0,1,2'b10,2'b10,1,0,0,0,0,1,0), 1'($urandom));
         push(mk(0,0,0,0,2'b01,2'b10,0,0,1,0,0,0,0), 1'($urandom));
      end else
         repeat (10) push(mk(0,0,0,0,0,0,0,0,0,0,0,0,1), 1'($urandom));
   endtask

   task automatic exec(input string tag, input int n);
      int k;
      k = (n < 0) ? exp_q.size() : n;
      for (int i = 0; i < k; i++) begin
         MemReady = rdy_q.pop_front();
         #1 chk(tag, exp_q.pop_front());
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1 chk("reset_vec", PCV);
      repeat (3) @(posedge clk);
      #2 chk("reset_hold", PCV);
      @(negedge clk) reset = 1'b1;
      build(2'b00, 6'b101000, 1'b0, 0, 0); exec("add_imm", -1);
      build(2'b01, 6'b011001, 1'b0, 0, 2); exec("ldr_wait", -1);
      build(2'b01, 6'b111000, 1'b0, 1, 0); exec("str_scaled", -1);
      build(2'b00, 6'b001000, 1'b1, 0, 0); exec("dp_rs", -1);
      build(2'b00, 6'b001000, 1'b0, 0, 0); exec("dp_r", -1);
      build(2'b10, 6'b010000, 1'b0, 0, 0); exec("bl", -1);
      build(2'b10, 6'b000000, 1'b0, 0, 0); exec("b", -1);
      build(2'b01, 6'b011000, 1'b0, 2, 3); exec("str_wait", -1);
      for (int i = 0; i < 150; i++) begin
         build(2'($urandom_range(0, 2)), 6'($urandom), 1'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 2));
         exec("random", -1);
      end
      build(2'b01, 6'b111000, 1'b0, 0, 0);
      exec("str_abort", 3);
      MemReady = 1'b0;
      #1 chk("memwr_hold", mk(0,0,1,0,0,0,0,1,0,0,0,0,0));
      reset = 1'b0;
      #1 chk("memwr_reset", PCV);
      exp_q.delete(); rdy_q.delete();
      @(negedge clk) reset = 1'b1;
      build(2'b11, 6'b000000, 1'b0, 0, 0); exec("illegal", -1);
      #2 reset = 1'b0;
      #1 chk("illegal_reset", PCV);
      @(negedge clk) reset = 1'b1;
      build(2'b00, 6'b101000, 1'b0, 1, 0); exec("after_err", -1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
